// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Two-master round-robin read arbiter in front of one shared memory port.
//   At most one transaction is in flight at a time: IDLE -> ADDR -> RESP -> IDLE.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   m0_req_i / m1_req_i      master read request (held until that master's gnt)
//   m0_addr_i / m1_addr_i    master byte address
//   m0_gnt_o / m1_gnt_o      address accepted (combinational from mem_gnt_i)
//   m0_rvalid_o / m1_rvalid_o read data valid (combinational from mem_rvalid_i)
//   m0_rdata_o / m1_rdata_o  read data, zero whenever the matching rvalid is 0
//   mem_req_o, mem_addr_o    request to the shared memory (driven only in ADDR)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  memory response
//   cnt0_o / cnt1_o          saturating count of completed reads per master
//   spurious_o               sticky flag for gnt/rvalid seen outside its phase
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m1_gnt_o,
  output logic                  m0_rvalid_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  cnt0_o,
  output logic [CNT_WIDTH-1:0]  cnt1_o,
  output logic                  spurious_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;   // 0 = m0, 1 = m1
  logic                    ptr_q, ptr_d;       // round-robin priority pointer
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0]    cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]    cnt1_q, cnt1_d;
  logic                    spur_q, spur_d;

  logic                    gnt_hit;
  logic                    rv_hit;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign gnt_hit = (state_q == S_ADDR) && mem_gnt_i;
  assign rv_hit  = (state_q == S_RESP) && mem_rvalid_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    spur_d  = spur_q;

    case (state_q)
      S_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          // Contention goes to the pointer; a lone requester always wins.
          owner_d = (m0_req_i && m1_req_i) ? ptr_q : m1_req_i;
          addr_d  = owner_d ? m1_addr_i : m0_addr_i;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (mem_gnt_i) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
          ptr_d   = ~owner_q;
          if (owner_q) cnt1_d = sat_inc(cnt1_q);
          else         cnt0_d = sat_inc(cnt0_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Out-of-phase handshakes only raise the flag; they never move the FSM.
    if ((mem_rvalid_i && state_q != S_RESP) || (mem_gnt_i && state_q != S_ADDR))
      spur_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      spur_q  <= spur_d;
    end
  end

  assign mem_req_o   = (state_q == S_ADDR);
  assign mem_addr_o  = (state_q == S_ADDR) ? addr_q : '0;

  assign m0_gnt_o    = gnt_hit && !owner_q;
  assign m1_gnt_o    = gnt_hit &&  owner_q;
  assign m0_rvalid_o = rv_hit  && !owner_q;
  assign m1_rvalid_o = rv_hit  &&  owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

  assign cnt0_o      = cnt0_q;
  assign cnt1_o      = cnt1_q;
  assign spurious_o  = spur_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed bench for memory_arbiter. The DUT is built with CNT_WIDTH=2 so
//   counter saturation is reachable; all other scenarios stay below 3.
//   Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
//   later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req_i, m1_req_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic          m0_gnt_o, m1_gnt_o;
  logic          m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic [CW-1:0] cnt0_o, cnt1_o;
  logic          spurious_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_req_i     (m0_req_i),
    .m0_addr_i    (m0_addr_i),
    .m1_req_i     (m1_req_i),
    .m1_addr_i    (m1_addr_i),
    .m0_gnt_o     (m0_gnt_o),
    .m1_gnt_o     (m1_gnt_o),
    .m0_rvalid_o  (m0_rvalid_o),
    .m1_rvalid_o  (m1_rvalid_o),
    .m0_rdata_o   (m0_rdata_o),
    .m1_rdata_o   (m1_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .cnt0_o       (cnt0_o),
    .cnt1_o       (cnt1_o),
    .spurious_o   (spurious_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Entered with the FSM in IDLE and the request(s) already driven.
  // Serves one read with gw gnt-wait cycles and rw rvalid-wait cycles.
  task automatic serve(input logic own, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input int gw, input int rw, input bit keep);
    step();                                    // now in ADDR
    check_eq("addr_req", {63'd0, mem_req_o}, 64'd1);
    check_eq("addr_val", {56'd0, mem_addr_o}, {56'd0, addr});
    for (int i = 0; i < gw; i++) begin
      check_eq("wait_gnt0", {63'd0, m0_gnt_o}, 64'd0);
      check_eq("wait_gnt1", {63'd0, m1_gnt_o}, 64'd0);
      step();
      check_eq("hold_req", {63'd0, mem_req_o}, 64'd1);
      check_eq("hold_addr", {56'd0, mem_addr_o}, {56'd0, addr});
    end
    mem_gnt_i = 1'b1;
    #1;
    check_eq("gnt_own", {63'd0, (own ? m1_gnt_o : m0_gnt_o)}, 64'd1);
    check_eq("gnt_other", {63'd0, (own ? m0_gnt_o : m1_gnt_o)}, 64'd0);
    step();                                    // now in RESP
    mem_gnt_i = 1'b0;
    if (!keep) begin
      if (own) m1_req_i = 1'b0;
      else     m0_req_i = 1'b0;
    end
    #1;
    check_eq("resp_noreq", {63'd0, mem_req_o}, 64'd0);
    check_eq("resp_noaddr", {56'd0, mem_addr_o}, 64'd0);
    for (int i = 0; i < rw; i++) begin
      step();
      check_eq("wait_rv", {62'd0, m1_rvalid_o, m0_rvalid_o}, 64'd0);
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = data;
    #1;
    check_eq("rv_own", {63'd0, (own ? m1_rvalid_o : m0_rvalid_o)}, 64'd1);
    check_eq("rv_other", {63'd0, (own ? m0_rvalid_o : m1_rvalid_o)}, 64'd0);
    check_eq("rdata_own", {32'd0, (own ? m1_rdata_o : m0_rdata_o)}, {32'd0, data});
    check_eq("rdata_other", {32'd0, (own ? m0_rdata_o : m1_rdata_o)}, 64'd0);
    step();                                    // back in IDLE
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0;
    m0_addr_i = '0; m1_addr_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    step();
    do_reset();

    // Reset state: every output quiet.
    check_eq("rst_memreq", {63'd0, mem_req_o}, 64'd0);
    check_eq("rst_gnt", {62'd0, m1_gnt_o, m0_gnt_o}, 64'd0);
    check_eq("rst_rv", {62'd0, m1_rvalid_o, m0_rvalid_o}, 64'd0);
    check_eq("rst_cnt", {60'd0, cnt1_o, cnt0_o}, 64'd0);
    check_eq("rst_spur", {63'd0, spurious_o}, 64'd0);

    // Single m0 read from zero-wait memory.
    m0_addr_i = 8'h04;
    m0_req_i  = 1'b1;
    serve(1'b0, 8'h04, 32'h0090_0093, 0, 0, 1'b0);
    check_eq("s1_cnt0", {62'd0, cnt0_o}, 64'd1);
    check_eq("s1_cnt1", {62'd0, cnt1_o}, 64'd0);
    check_eq("s1_spur", {63'd0, spurious_o}, 64'd0);

    // Both masters request continuously: strict alternation starting at m0.
    do_reset();
    m0_addr_i = 8'h10;
    m1_addr_i = 8'h20;
    m0_req_i  = 1'b1;
    m1_req_i  = 1'b1;
    serve(1'b0, 8'h10, 32'hA000_0001, 0, 0, 1'b1);
    serve(1'b1, 8'h20, 32'hB000_0002, 0, 0, 1'b1);
    serve(1'b0, 8'h10, 32'hA000_0003, 0, 0, 1'b1);
    serve(1'b1, 8'h20, 32'hB000_0004, 0, 0, 1'b1);
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    check_eq("rr_cnt0", {62'd0, cnt0_o}, 64'd2);
    check_eq("rr_cnt1", {62'd0, cnt1_o}, 64'd2);

    // Slow memory: 3 gnt-wait cycles, 2 rvalid-wait cycles, owner m1.
    do_reset();
    m1_addr_i = 8'h3C;
    m1_req_i  = 1'b1;
    serve(1'b1, 8'h3C, 32'hDEAD_BEEF, 3, 2, 1'b0);
    check_eq("slow_cnt0", {62'd0, cnt0_o}, 64'd0);
    check_eq("slow_cnt1", {62'd0, cnt1_o}, 64'd1);
    check_eq("slow_idle", {63'd0, mem_req_o}, 64'd0);

    // Spurious rvalid in IDLE.
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #1;
    check_eq("sp_norv", {62'd0, m1_rvalid_o, m0_rvalid_o}, 64'd0);
    check_eq("sp_nodata", {m1_rdata_o, m0_rdata_o}, 64'd0);
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    check_eq("sp_flag", {63'd0, spurious_o}, 64'd1);
    check_eq("sp_cnt", {60'd0, cnt1_o, cnt0_o}, {60'd0, 2'd1, 2'd0});
    check_eq("sp_idle", {63'd0, mem_req_o}, 64'd0);
    step();
    step();
    check_eq("sp_sticky", {63'd0, spurious_o}, 64'd1);

    // Reset while in RESP, then a late rvalid.
    do_reset();
    check_eq("mr_spur0", {63'd0, spurious_o}, 64'd0);
    m0_addr_i = 8'h44;
    m0_req_i  = 1'b1;
    step();                                    // ADDR
    mem_gnt_i = 1'b1;
    step();                                    // RESP
    mem_gnt_i = 1'b0;
    m0_req_i  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mr_req", {63'd0, mem_req_o}, 64'd0);
    check_eq("mr_cnt", {60'd0, cnt1_o, cnt0_o}, 64'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    #1;
    check_eq("mr_norv", {62'd0, m1_rvalid_o, m0_rvalid_o}, 64'd0);
    check_eq("mr_nodata", {32'd0, m0_rdata_o}, 64'd0);
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    check_eq("mr_spur", {63'd0, spurious_o}, 64'd1);
    check_eq("mr_cnt_after", {60'd0, cnt1_o, cnt0_o}, 64'd0);
    check_eq("mr_idle", {63'd0, mem_req_o}, 64'd0);

    // m1 completes 5 reads; 2-bit counter sticks at 3.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      m1_addr_i = 8'(8'h80 + 4 * k);
      m1_req_i  = 1'b1;
      serve(1'b1, 8'(8'h80 + 4 * k), 32'h5000_0000 + k, 0, 0, 1'b0);
      check_eq("sat_cnt1", {62'd0, cnt1_o}, (k < 3) ? 64'(k + 1) : 64'd3);
    end
    check_eq("sat_cnt0", {62'd0, cnt0_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, transaction counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports m0_req_i/m1_req_i  input  1 each  master read request; held high until that master's gnt.
REQ-007 SHALL have ports m0_addr_i/m1_addr_i  input  ADDR_WIDTH each  master byte address.
REQ-008 SHALL have ports m0_gnt_o/m1_gnt_o  output  1 each  address accepted.
REQ-009 SHALL have ports m0_rvalid_o/m1_rvalid_o  output  1 each  read data valid.
REQ-010 SHALL have ports m0_rdata_o/m1_rdata_o  output  DATA_WIDTH each  read data.
REQ-011 SHALL have ports mem_req_o (1), mem_addr_o (ADDR_WIDTH)  outputs  request to shared memory.
REQ-012 SHALL have ports mem_gnt_i (1), mem_rvalid_i (1), mem_rdata_i (DATA_WIDTH)  inputs  memory response.
REQ-013 SHALL have ports cnt0_o/cnt1_o  output  CNT_WIDTH each  completed transactions per master.
REQ-014 SHALL have port spurious_o  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL implement FSM IDLE -> ADDR -> RESP -> IDLE, one outstanding transaction at most.
REQ-016 SHALL, in IDLE with any req high, select one master, latch its id as owner and its address, and enter ADDR next cycle.
REQ-017 SHALL arbitrate round-robin: priority pointer starts at m0; if both request, pointer's master wins; single requester wins regardless of pointer.
REQ-018 SHALL, after each completed transaction, set pointer to the master that was not owner.
REQ-019 SHALL drive mem_req_o=1 and mem_addr_o=latched address only in ADDR; mem_req_o=0, mem_addr_o=0 otherwise.
REQ-020 SHALL, in ADDR with mem_gnt_i=1, pulse owner's mX_gnt_o combinationally in that cycle and enter RESP next cycle.
REQ-021 SHALL remain in ADDR indefinitely while mem_gnt_i=0, holding mem_req_o/mem_addr_o stable.
REQ-022 SHALL, in RESP with mem_rvalid_i=1, pass mem_rdata_i to owner's mX_rdata_o and pulse owner's mX_rvalid_o combinationally that cycle, then return to IDLE.
REQ-023 SHALL hold non-owner gnt/rvalid at 0 and all mX_rdata_o at 0 when their rvalid is 0.
REQ-024 SHALL increment owner's counter on the rvalid cycle; saturate at all-ones (no wrap).
REQ-025 SHALL set spurious_o on mem_rvalid_i=1 in IDLE or ADDR, or mem_gnt_i=1 in IDLE or RESP; such events change no other state.
REQ-026 SHALL ignore a master request arriving in ADDR/RESP until IDLE; minimum request-to-request spacing is therefore 3 cycles with zero-wait memory.
REQ-027 SHALL sample new requests only in IDLE; a request present on the IDLE-return cycle is arbitrated in the following IDLE cycle.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, force IDLE, pointer=m0, owner=m0, latched address=0, counters=0, spurious_o=0, regardless of state.
REQ-029 SHALL, while in IDLE after reset, present all outputs 0.
REQ-030 SHALL abandon an in-flight transaction on reset mid-ADDR/RESP; a subsequent late mem_rvalid_i sets spurious_o.

Verification
REQ-031 SHALL verify: m0 reads addr 0x04 from zero-wait memory holding 0x00900093 -> mem_req_o cycle 1, m0_gnt_o same cycle as mem_gnt_i, m0_rvalid_o with 0x00900093, cnt0_o=1.
REQ-032 SHALL verify: m0 and m1 request together continuously for 4 transactions -> order m0,m1,m0,m1; cnt0_o=cnt1_o=2.
REQ-033 SHALL verify: memory delays gnt 3 cycles and rvalid 2 cycles -> mem_req_o/mem_addr_o stable 4 cycles, single rvalid to owner only.
REQ-034 SHALL verify: mem_rvalid_i pulsed in IDLE -> spurious_o=1 and stays 1; no master rvalid; counters unchanged.
REQ-035 SHALL verify: rst asserted in RESP, then late mem_rvalid_i -> FSM IDLE, counters 0, no master rvalid, spurious_o=1.
REQ-036 SHALL verify: with CNT_WIDTH=2, m1 completes 5 reads -> cnt1_o saturates at 3.
